// File: rtl/decoder_8_bit_strobe.sv
// Purpose : decodes a 3-bit code into a registered one-hot strobe PULSE_LEN cycles wide,
//           followed by GAP_LEN forced-idle cycles before the next strobe may start.
// Latency : onehot is valid one cycle after the accepting transfer; done is combinational from state.
// Backpr. : in_ready is low while a strobe/gap is in progress, and also during abort or reset.
//           With DECODER_8_BIT_STROBE_QUEUE_EN defined, one code can be held pending while busy.
// Ports   : clock, reset_n (async active-low), code/in_valid/in_ready (valid-ready input),
//           abort (sync cancel), onehot[7:0], busy, done.
module decoder_8_bit_strobe #(
    parameter int PULSE_LEN = 4,
    parameter int GAP_LEN   = 1
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] code,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    output logic [7:0] onehot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [7:0] PULSE_LOAD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] GAP_LOAD   = 8'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam bit         HAS_GAP    = (GAP_LEN > 0);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [2:0] code_q, code_d;
    logic [7:0] onehot_q, onehot_d;

    logic       xfer;
    logic       decide;
    logic       nxt_vld;
    logic [2:0] nxt_code;

`ifdef DECODER_8_BIT_STROBE_QUEUE_EN
    logic       pend_vld_q, pend_vld_d;
    logic [2:0] pend_code_q, pend_code_d;

    // Pending entry wins over a same-cycle transfer; a same-cycle transfer is only
    // possible at a decision when the pending slot is empty.
    assign in_ready = reset_n && ((state_q == IDLE) || !pend_vld_q) && !abort;
    assign nxt_vld  = pend_vld_q || xfer;
    assign nxt_code = pend_vld_q ? pend_code_q : code;
`else
    assign in_ready = reset_n && (state_q == IDLE) && !abort;
    assign nxt_vld  = 1'b0;
    assign nxt_code = code;
`endif

    assign xfer = in_valid && in_ready;

    // Decision point: last gap cycle, or last drive cycle when there is no gap.
    assign decide = (cnt_q == 8'd0) &&
                    ((state_q == GAP) || ((state_q == DRIVE) && !HAS_GAP));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        code_d   = code_q;
        onehot_d = 8'h00;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    state_d = DRIVE;
                    cnt_d   = PULSE_LOAD;
                    code_d  = code;
                end
            end
            DRIVE, GAP: begin
                if (decide) begin
                    if (nxt_vld) begin
                        state_d = DRIVE;
                        cnt_d   = PULSE_LOAD;
                        code_d  = nxt_code;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = 8'd0;
                    end
                end else if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    // Only reachable from DRIVE with a non-zero gap.
                    state_d = GAP;
                    cnt_d   = GAP_LOAD;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        if (abort) begin
            state_d = IDLE;
            cnt_d   = 8'd0;
        end
        // code_d only changes when a new strobe starts, so onehot is stable mid-strobe.
        if (state_d == DRIVE) begin
            onehot_d = 8'h01 << code_d;
        end
    end

`ifdef DECODER_8_BIT_STROBE_QUEUE_EN
    always_comb begin
        pend_vld_d  = pend_vld_q;
        pend_code_d = pend_code_q;
        if (abort) begin
            pend_vld_d = 1'b0;
        end else if (decide && pend_vld_q) begin
            pend_vld_d = 1'b0;
        end else if (xfer && (state_q != IDLE) && !decide) begin
            pend_vld_d  = 1'b1;
            pend_code_d = code;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pend_vld_q  <= 1'b0;
            pend_code_q <= 3'd0;
        end else begin
            pend_vld_q  <= pend_vld_d;
            pend_code_q <= pend_code_d;
        end
    end
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= 8'd0;
            code_q   <= 3'd0;
            onehot_q <= 8'h00;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            code_q   <= code_d;
            onehot_q <= onehot_d;
        end
    end

    assign onehot = onehot_q;
    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DRIVE) && (cnt_q == 8'd0) && !abort;

endmodule

// File: tb/tb_decoder_8_bit_strobe.sv
// Purpose : self-checking bench for decoder_8_bit_strobe (two instances: 4/1 and 2/0 pulse/gap).
// Latency : expectations are per-cycle tuples queued with stimulus and popped one cycle at a time.
// Backpr. : in_ready expectations follow the build (pending slot present or not).
module tb_decoder_8_bit_strobe;

`ifdef DECODER_8_BIT_STROBE_QUEUE_EN
    localparam bit QEN = 1'b1;
`else
    localparam bit QEN = 1'b0;
`endif

    typedef struct packed {
        logic [7:0] oh;
        logic       dn;
        logic       bz;
        logic       rdy;
    } exp_t;

    typedef struct packed {
        logic       v;
        logic [2:0] c;
        logic       ab;
    } stim_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [2:0] a_code = 3'd0, b_code = 3'd0;
    logic       a_vld = 1'b0, b_vld = 1'b0;
    logic       a_abort = 1'b0, b_abort = 1'b0;
    logic       a_rdy, b_rdy, a_busy, b_busy, a_done, b_done;
    logic [7:0] a_oh, b_oh;

    exp_t  obs_a, obs_b;
    exp_t  exp_q[$];
    stim_t stim_q[$];
    int    total = 0;
    int    bad = 0;

    assign obs_a = {a_oh, a_done, a_busy, a_rdy};
    assign obs_b = {b_oh, b_done, b_busy, b_rdy};

    always #5 clock = ~clock;

    decoder_8_bit_strobe #(.PULSE_LEN(4), .GAP_LEN(1)) dut_a (
        .clock(clock), .reset_n(reset_n), .code(a_code), .in_valid(a_vld),
        .in_ready(a_rdy), .abort(a_abort), .onehot(a_oh), .busy(a_busy), .done(a_done)
    );

    decoder_8_bit_strobe #(.PULSE_LEN(2), .GAP_LEN(0)) dut_b (
        .clock(clock), .reset_n(reset_n), .code(b_code), .in_valid(b_vld),
        .in_ready(b_rdy), .abort(b_abort), .onehot(b_oh), .busy(b_busy), .done(b_done)
    );

    function automatic exp_t mk(input logic [7:0] oh, input logic dn, input logic bz, input logic rdy);
        return {oh, dn, bz, rdy};
    endfunction

    function automatic stim_t st(input logic v, input logic [2:0] c, input logic ab);
        return {v, c, ab};
    endfunction

    function automatic string fmt(input exp_t x);
        return $sformatf("oh=%h done=%b busy=%b rdy=%b", x.oh, x.dn, x.bz, x.rdy);
    endfunction

    task automatic push(input stim_t s, input exp_t e);
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Drive one cycle's inputs just after the rising edge, then settle before sampling.
    task automatic step_a(input stim_t s);
        @(posedge clock);
        #1;
        a_vld = s.v; a_code = s.c; a_abort = s.ab;
        #1;
    endtask

    task automatic step_b(input stim_t s);
        @(posedge clock);
        #1;
        b_vld = s.v; b_code = s.c; b_abort = s.ab;
        #1;
    endtask

    task automatic test_reset;
        a_vld = 1'b1; b_vld = 1'b1;
        #3;
        total++;
        if (obs_a !== mk(8'h00, 1'b0, 1'b0, 1'b0)) begin
            bad++; $display("FAIL reset_a got %s want %s", fmt(obs_a), fmt(mk(8'h00, 1'b0, 1'b0, 1'b0)));
        end
        total++;
        if (obs_b !== mk(8'h00, 1'b0, 1'b0, 1'b0)) begin
            bad++; $display("FAIL reset_b got %s want %s", fmt(obs_b), fmt(mk(8'h00, 1'b0, 1'b0, 1'b0)));
        end
        @(negedge clock);
        reset_n = 1'b1; a_vld = 1'b0; b_vld = 1'b0;
        #1;
        total++;
        if (obs_a !== mk(8'h00, 1'b0, 1'b0, 1'b1)) begin
            bad++; $display("FAIL reset_release got %s want %s", fmt(obs_a), fmt(mk(8'h00, 1'b0, 1'b0, 1'b1)));
        end
    endtask

    task automatic test_single;
        int cyc = 0;
        stim_t s; exp_t e;
        push(st(1'b1, 3'd5, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
        for (int k = 0; k < 4; k++) push(st(1'b0, 3'd0, 1'b0), mk(8'h20, k == 3, 1'b1, QEN));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h00, 1'b0, 1'b1, QEN));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            step_a(s);
            total++;
            if (obs_a !== e) begin
                bad++; $display("FAIL single cyc=%0d got %s want %s", cyc, fmt(obs_a), fmt(e));
            end
            cyc++;
        end
    endtask

    task automatic test_sweep;
        int cyc = 0;
        stim_t s; exp_t e;
        logic [7:0] oh;
        for (int c = 0; c < 8; c++) begin
            oh = 8'h01 << c;
            push(st(1'b1, 3'(c), 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
            for (int k = 0; k < 4; k++) push(st(1'b0, 3'd0, 1'b0), mk(oh, k == 3, 1'b1, QEN));
            push(st(1'b0, 3'd0, 1'b0), mk(8'h00, 1'b0, 1'b1, QEN));
        end
        push(st(1'b0, 3'd0, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            step_a(s);
            total++;
            if (obs_a !== e) begin
                bad++; $display("FAIL sweep cyc=%0d got %s want %s", cyc, fmt(obs_a), fmt(e));
            end
            if (e.oh != 8'h00) begin
                total++;
                if ($countones(a_oh) != 1) begin
                    bad++; $display("FAIL sweep_onehot cyc=%0d got bits=%0d want 1", cyc, $countones(a_oh));
                end
            end
            cyc++;
        end
    endtask

    task automatic test_back_to_back;
        int cyc = 0;
        stim_t s; exp_t e;
        push(st(1'b1, 3'd1, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
`ifdef DECODER_8_BIT_STROBE_QUEUE_EN
        push(st(1'b1, 3'd6, 1'b0), mk(8'h02, 1'b0, 1'b1, 1'b1));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h02, 1'b1, 1'b1, 1'b0));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h40, 1'b0, 1'b1, 1'b1));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h40, 1'b1, 1'b1, 1'b1));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
`else
        push(st(1'b1, 3'd6, 1'b0), mk(8'h02, 1'b0, 1'b1, 1'b0));
        push(st(1'b1, 3'd6, 1'b0), mk(8'h02, 1'b1, 1'b1, 1'b0));
        push(st(1'b1, 3'd6, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h40, 1'b0, 1'b1, 1'b0));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h40, 1'b1, 1'b1, 1'b0));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
`endif
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            step_b(s);
            total++;
            if (obs_b !== e) begin
                bad++; $display("FAIL back_to_back cyc=%0d got %s want %s", cyc, fmt(obs_b), fmt(e));
            end
            cyc++;
        end
    endtask

    task automatic test_abort;
        int cyc = 0;
        stim_t s; exp_t e;
        // Abort mid-strobe while code 3 is offered (pending when the slot exists).
        push(st(1'b1, 3'd5, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
        push(st(1'b1, 3'd3, 1'b0), mk(8'h20, 1'b0, 1'b1, QEN));
        push(st(1'b0, 3'd0, 1'b1), mk(8'h20, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 5; k++) push(st(1'b0, 3'd0, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
        // Abort on the last drive cycle: done must be suppressed.
        push(st(1'b1, 3'd4, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
        for (int k = 0; k < 3; k++) push(st(1'b0, 3'd0, 1'b0), mk(8'h10, 1'b0, 1'b1, QEN));
        push(st(1'b0, 3'd0, 1'b1), mk(8'h10, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 2; k++) push(st(1'b0, 3'd0, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            step_a(s);
            total++;
            if (obs_a !== e) begin
                bad++; $display("FAIL abort cyc=%0d got %s want %s", cyc, fmt(obs_a), fmt(e));
            end
            cyc++;
        end
    endtask

    task automatic test_hold_valid;
        int cyc = 0;
        stim_t s; exp_t e;
        push(st(1'b1, 3'd7, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
`ifdef DECODER_8_BIT_STROBE_QUEUE_EN
        push(st(1'b1, 3'd2, 1'b0), mk(8'h80, 1'b0, 1'b1, 1'b1));
        for (int k = 1; k < 4; k++) push(st(1'b0, 3'd0, 1'b0), mk(8'h80, k == 3, 1'b1, 1'b0));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h00, 1'b0, 1'b1, 1'b0));
        for (int k = 0; k < 4; k++) push(st(1'b0, 3'd0, 1'b0), mk(8'h04, k == 3, 1'b1, 1'b1));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h00, 1'b0, 1'b1, 1'b1));
`else
        for (int k = 0; k < 4; k++) push(st(1'b1, 3'd2, 1'b0), mk(8'h80, k == 3, 1'b1, 1'b0));
        push(st(1'b1, 3'd2, 1'b0), mk(8'h00, 1'b0, 1'b1, 1'b0));
        push(st(1'b1, 3'd2, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
        for (int k = 0; k < 4; k++) push(st(1'b0, 3'd0, 1'b0), mk(8'h04, k == 3, 1'b1, 1'b0));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h00, 1'b0, 1'b1, 1'b0));
`endif
        push(st(1'b0, 3'd0, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            step_a(s);
            total++;
            if (obs_a !== e) begin
                bad++; $display("FAIL hold_valid cyc=%0d got %s want %s", cyc, fmt(obs_a), fmt(e));
            end
            cyc++;
        end
    endtask

    task automatic test_reset_mid;
        int cyc = 0;
        stim_t s; exp_t e;
        push(st(1'b1, 3'd5, 1'b0), mk(8'h00, 1'b0, 1'b0, 1'b1));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h20, 1'b0, 1'b1, QEN));
        push(st(1'b0, 3'd0, 1'b0), mk(8'h20, 1'b0, 1'b1, QEN));
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            step_a(s);
            total++;
            if (obs_a !== e) begin
                bad++; $display("FAIL reset_mid cyc=%0d got %s want %s", cyc, fmt(obs_a), fmt(e));
            end
            cyc++;
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (obs_a !== mk(8'h00, 1'b0, 1'b0, 1'b0)) begin
            bad++; $display("FAIL reset_mid_async got %s want %s", fmt(obs_a), fmt(mk(8'h00, 1'b0, 1'b0, 1'b0)));
        end
        a_vld = 1'b1; a_code = 3'd2;
        @(posedge clock);
        #1;
        total++;
        if (obs_a !== mk(8'h00, 1'b0, 1'b0, 1'b0)) begin
            bad++; $display("FAIL reset_mid_held got %s want %s", fmt(obs_a), fmt(mk(8'h00, 1'b0, 1'b0, 1'b0)));
        end
        @(negedge clock);
        a_vld = 1'b0;
        reset_n = 1'b1;
        #1;
        total++;
        if (obs_a !== mk(8'h00, 1'b0, 1'b0, 1'b1)) begin
            bad++; $display("FAIL reset_mid_release got %s want %s", fmt(obs_a), fmt(mk(8'h00, 1'b0, 1'b0, 1'b1)));
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_sweep();
        test_back_to_back();
        test_abort();
        test_hold_valid();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
